debug_uart_streamer: RTL and testbench
======================================

Name: debug_uart_streamer

Overview:
- Downstream consumer of the CPU's seven 8-bit debug ports.
- On each trigger edge, snapshots all seven bytes and serializes them as one framed UART (8N1) packet on a single tx line to the host serial-port debugger.
- Frame format: sync byte 0xA5, then payload debug_port1..debug_port7 in order, then an XOR checksum byte.
- Sits between cpu and the board's UART TX pin; no receive path.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit; legal range >= 2; the counter width is derived from it.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock
- nreset  input  1  asynchronous active-low reset
- trigger  input  1  snapshot request; only rising edges count
- debug_port1..debug_port7  input  8 each  payload bytes from cpu
- tx  output  1  UART serial out; idle high
- busy  output  1  high while a frame is in flight
- frames_sent  output  8  completed-frame count; wraps 255->0
- dropped  output  8  triggers rejected while busy; saturates at 255

Behaviour:
- Reset (nreset low, asynchronous): tx=1, busy=0, frames_sent=0, dropped=0, state=IDLE, internal trigger delay register=0.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned; no partial count.
- Edge detect: rise = trigger & ~trig_q, where trig_q is trigger registered every cycle.
- States: IDLE, START, DATA, STOP. Byte index 0..8 selects sync, payload 1..7, or checksum. Bit index 0..7. Baud counter runs 0..CLKS_PER_BIT-1.
- IDLE: tx=1, busy=0.
  - On rise: capture all seven debug ports and the checksum (XOR of the 7 payload bytes) into a 9-byte shadow. Clear byte index to 0 and go to START.
  - The inputs are not sampled again until the next accepted trigger.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = current_byte[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte index < 8: increment it and go to START.
  - Otherwise: go to IDLE and increment frames_sent in the same cycle.
- busy is registered. It is 1 from the cycle tx first drops for the sync start bit until the cycle state returns to IDLE.
- Latency: a rise sampled at edge T gives tx=0 and busy=1 after edge T.
- Frame length: exactly 9*10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- Back-to-back frames: a rise sampled in the IDLE cycle right after a frame ends is accepted. The minimum inter-frame idle is therefore 1 cycle of tx=1.
- Rise while busy: the frame in flight is unaffected; dropped += 1, saturating at 255; no request is queued.
- The trigger rise and the frame-completion transition never coincide as acceptance: IDLE is the only accepting state.
- Payload changes during a frame are ignored because only the shadow is transmitted.
- Trigger held high continuously produces exactly one frame.
- All outputs are registered; tx is glitch-free.

Test Plan (CLKS_PER_BIT=4):
- Reset release with trigger=0 for 100 cycles -> tx=1, busy=0, frames_sent=0, dropped=0 throughout.
- Ports = 00,04,08,00,01,02,07, one trigger pulse -> the bench UART decoder (sampling at bit centres) receives A5 00 04 08 00 01 02 07 08. busy is high exactly 360 cycles. frames_sent=1.
- Same frame; change all debug ports to FF at cycle 50 of the frame -> decoded bytes are unchanged from the previous scenario.
- Second trigger pulse at cycle 100 of a frame, third at cycle 200 -> one frame is sent, dropped=2. A trigger in the first IDLE cycle after busy falls is accepted with a 1-cycle tx-high gap.
- trigger held high 1000 cycles -> exactly one frame, dropped=0. Then 300 pulses issued while busy -> dropped saturates at 255.
- Assert nreset during DATA of byte 3 -> tx=1 and busy=0 asynchronously, frames_sent unchanged at 0. The next trigger after release yields a complete, correct frame.

Source files
------------

// File: rtl/debug_uart_streamer_if.sv
// debug_uart_streamer_if: cpu debug-port inputs and UART/status outputs of the streamer
interface debug_uart_streamer_if;
   logic       trigger;
   logic [7:0] debug_port1, debug_port2, debug_port3, debug_port4;
   logic [7:0] debug_port5, debug_port6, debug_port7;
   logic       tx;
   logic       busy;
   logic [7:0] frames_sent;
   logic [7:0] dropped;
   modport master (
      output trigger, debug_port1, debug_port2, debug_port3, debug_port4,
             debug_port5, debug_port6, debug_port7,
      input  tx, busy, frames_sent, dropped
   );
   modport slave (
      input  trigger, debug_port1, debug_port2, debug_port3, debug_port4,
             debug_port5, debug_port6, debug_port7,
      output tx, busy, frames_sent, dropped
   );
endinterface

// File: rtl/debug_uart_streamer.sv
// debug_uart_streamer: snapshots seven debug bytes on a trigger edge and sends them
// as an 8N1 frame: sync byte, payload 1..7, XOR checksum.
module debug_uart_streamer #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input logic clk,
   input logic nreset,
   debug_uart_streamer_if.slave s
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [2:0]      bit_idx, bit_nx;
   logic [3:0]      byte_idx, byte_nx;
   logic [8:0][7:0] frame;
   logic [7:0]      cks;
   logic            trig_q, rise, last, done, tx_nx;
   assign rise = s.trigger & ~trig_q;
   assign last = cnt == LAST;
   assign cks  = s.debug_port1 ^ s.debug_port2 ^ s.debug_port3 ^ s.debug_port4 ^
                 s.debug_port5 ^ s.debug_port6 ^ s.debug_port7;
   always_comb begin
      state_nx = state;
      bit_nx   = bit_idx;
      byte_nx  = byte_idx;
      done     = 1'b0;
      cnt_nx   = (state == IDLE || last) ? '0 : cnt + 1'b1;
      case (state)
         IDLE: if (rise) begin
            state_nx = START;
            byte_nx  = '0;
         end
         START: if (last) begin
            state_nx = DATA;
            bit_nx   = '0;
         end
         DATA: if (last) begin
            state_nx = (bit_idx == 3'd7) ? STOP : DATA;
            bit_nx   = bit_idx + 1'b1;
         end
         STOP: if (last) begin
            state_nx = (byte_idx < 4'd8) ? START : IDLE;
            byte_nx  = (byte_idx < 4'd8) ? byte_idx + 1'b1 : byte_idx;
            done     = byte_idx == 4'd8;
         end
         default: state_nx = IDLE;
      endcase
   end
   // tx is computed from next state so the registered line changes with the state
   assign tx_nx = (state_nx == START) ? 1'b0 :
                  (state_nx == DATA)  ? frame[byte_nx][bit_nx] : 1'b1;
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         byte_idx      <= '0;
         frame         <= '0;
         trig_q        <= 1'b0;
         s.tx          <= 1'b1;
         s.busy        <= 1'b0;
         s.frames_sent <= '0;
         s.dropped     <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         bit_idx  <= bit_nx;
         byte_idx <= byte_nx;
         trig_q   <= s.trigger;
         s.tx     <= tx_nx;
         s.busy   <= state_nx != IDLE;
         if (state == IDLE && rise)
            frame <= {cks, s.debug_port7, s.debug_port6, s.debug_port5, s.debug_port4,
                      s.debug_port3, s.debug_port2, s.debug_port1, SYNC_BYTE};
         if (done)
            s.frames_sent <= s.frames_sent + 1'b1;
         if (rise && state != IDLE && s.dropped != 8'hFF)
            s.dropped <= s.dropped + 1'b1;
      end
   end
endmodule

// File: tb/tb_debug_uart_streamer.sv
// tb_debug_uart_streamer: directed frames with a UART-decoding monitor that checks
// received bytes against a scoreboard queue, plus status/counter checks.
module tb_debug_uart_streamer;
   localparam int N = 4;
   logic clk, nreset;
   int n_tests = 0, n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] cur[8];
   debug_uart_streamer_if bus();
   debug_uart_streamer #(.CLKS_PER_BIT(N), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .nreset(nreset), .s(bus.slave)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_frame(input logic [7:0] a, b, c, d, e, f, g, ck);
      bus.debug_port1 = a; bus.debug_port2 = b; bus.debug_port3 = c; bus.debug_port4 = d;
      bus.debug_port5 = e; bus.debug_port6 = f; bus.debug_port7 = g;
      cur = '{a, b, c, d, e, f, g, ck};
   endtask

   task automatic push_exp();
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 8; i++) exp_q.push_back(cur[i]);
   endtask

   task automatic start_frame();
      push_exp();
      bus.trigger = 1'b1;
      tick();
      chk("start_busy", int'(bus.busy), 1);
      chk("start_tx", int'(bus.tx), 0);
      bus.trigger = 1'b0;
   endtask

   task automatic pulse();
      bus.trigger = 1'b1;
      tick();
      bus.trigger = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 2000) begin
         cyc++;
         tick();
      end
      if (cyc >= 2000) chk("busy_timeout", cyc, 0);
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      tick();
      tick();
      nreset = 1'b1;
      tick();
      chk("rst_frames", int'(bus.frames_sent), 0);
      chk("rst_dropped", int'(bus.dropped), 0);
   endtask

   // UART decoder sampling at bit centres; a byte interrupted by reset is discarded
   initial begin : mon
      logic [7:0] b;
      logic st, sp;
      bit ok;
      forever begin
         tick();
         if (nreset && bus.tx === 1'b0) begin
            ok = 1;
            repeat (N / 2) begin tick(); if (!nreset) ok = 0; end
            st = bus.tx;
            for (int i = 0; i < 8; i++) begin
               repeat (N) begin tick(); if (!nreset) ok = 0; end
               b[i] = bus.tx;
            end
            repeat (N) begin tick(); if (!nreset) ok = 0; end
            sp = bus.tx;
            if (ok) begin
               if (exp_q.size() == 0) chk("unexpected_byte", int'(b), -1);
               else chk("byte", int'(b), int'(exp_q.pop_front()));
               chk("framing", int'({st, sp}), 1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      nreset = 1'b0;
      bus.trigger = 1'b0;
      set_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) tick();
      chk("rst_tx", int'(bus.tx), 1);
      chk("rst_busy", int'(bus.busy), 0);
      nreset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("idle_state", int'({bus.tx, bus.busy, bus.frames_sent, bus.dropped}), 18'h20000);
      end
      // basic frame
      set_frame(8'h00, 8'h04, 8'h08, 8'h00, 8'h01, 8'h02, 8'h07, 8'h08);
      start_frame();
      wait_idle(cyc);
      chk("busy_len", cyc, 360);
      chk("frames_1", int'(bus.frames_sent), 1);
      repeat (5) tick();
      // payload changes mid-frame must not leak into the shadow
      start_frame();
      repeat (49) tick();
      set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      wait_idle(cyc);
      chk("busy_len_2", cyc + 49, 360);
      chk("frames_2", int'(bus.frames_sent), 2);
      repeat (5) tick();
      // triggers while busy, then back-to-back acceptance
      set_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F);
      start_frame();
      repeat (99) tick();
      pulse();
      repeat (99) tick();
      pulse();
      wait_idle(cyc);
      chk("busy_len_3", cyc + 200, 360);
      chk("dropped_2", int'(bus.dropped), 2);
      chk("frames_3", int'(bus.frames_sent), 3);
      chk("gap_tx", int'(bus.tx), 1);
      set_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00);
      start_frame();
      wait_idle(cyc);
      chk("busy_len_4", cyc, 360);
      chk("frames_4", int'(bus.frames_sent), 4);
      chk("dropped_keep", int'(bus.dropped), 2);
      repeat (5) tick();
      // held trigger gives one frame; then saturate dropped
      do_reset();
      set_frame(8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h81, 8'h7E);
      push_exp();
      bus.trigger = 1'b1;
      repeat (1000) tick();
      bus.trigger = 1'b0;
      tick();
      chk("held_frames", int'(bus.frames_sent), 1);
      chk("held_dropped", int'(bus.dropped), 0);
      chk("held_busy", int'(bus.busy), 0);
      start_frame();
      tick();
      repeat (150) begin pulse(); tick(); end
      wait_idle(cyc);
      chk("dropped_150", int'(bus.dropped), 150);
      repeat (3) tick();
      start_frame();
      tick();
      repeat (150) begin pulse(); tick(); end
      wait_idle(cyc);
      chk("dropped_sat", int'(bus.dropped), 255);
      chk("frames_sat", int'(bus.frames_sent), 3);
      repeat (5) tick();
      // reset during byte 3 data bits
      do_reset();
      set_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
      start_frame();
      repeat (129) tick();
      nreset = 1'b0;
      #1;
      chk("abort_tx", int'(bus.tx), 1);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_frames", int'(bus.frames_sent), 0);
      tick();
      nreset = 1'b1;
      repeat (60) tick();
      chk("abort_left", exp_q.size(), 6);
      exp_q.delete();
      chk("abort_frames_2", int'(bus.frames_sent), 0);
      start_frame();
      wait_idle(cyc);
      chk("busy_len_5", cyc, 360);
      chk("frames_after", int'(bus.frames_sent), 1);
      repeat (20) tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
